tetris_input_sched: RTL and testbench

Cycle-level scheduler between the keyboard keycode and the falling-piece engine on the playfield grid. It converts raw keycodes and a gravity timer into single-step piece commands: LEFT, RIGHT, ROT, DOWN and HARD. It arbitrates them by fixed priority and offers one command at a time over a valid/ready handshake. It runs in the `frame_clk` domain alongside the piece/grid engine.

---
 rtl/tetris_input_sched_if.sv | 19 +
 rtl/tetris_input_sched.sv | 148 ++++++++++++++
 tb/tb_tetris_input_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_sched_if.sv
// Command handshake bundle between the input scheduler and the piece engine.
interface tetris_input_sched_if;
  logic [7:0] keycode;
  logic       enable;
  logic [5:0] gravity_period;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd;

  modport master (
    input  keycode, enable, gravity_period, cmd_ready,
    output cmd_valid, cmd
  );

  modport slave (
    output keycode, enable, gravity_period, cmd_ready,
    input  cmd_valid, cmd
  );
endinterface

// File: rtl/tetris_input_sched.sv
// Turns keycodes and a gravity timer into prioritised single-step piece commands over valid/ready.
// LEFT/RIGHT DAS/ARR auto-repeat is compiled in only when TETRIS_AUTOREPEAT_EN is defined.
module tetris_input_sched #(
  parameter int         DAS_FRAMES  = 10,
  parameter int         ARR_FRAMES  = 3,
  parameter int         SOFT_PERIOD = 2,
  parameter logic [7:0] KEY_LEFT    = 8'h04,
  parameter logic [7:0] KEY_RIGHT   = 8'h07,
  parameter logic [7:0] KEY_ROT     = 8'h1A,
  parameter logic [7:0] KEY_SOFT    = 8'h16,
  parameter logic [7:0] KEY_HARD    = 8'h2C
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  tetris_input_sched_if.master bus
);
  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;
  localparam logic [2:0] CMD_HARD  = 3'd5;
  localparam logic [5:0] SOFT_P    = (SOFT_PERIOD < 1) ? 6'd1 : 6'(SOFT_PERIOD);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state;
  logic [7:0] key_prev, grav_cnt, grav_next, period8;
  logic [5:0] gp_eff, period;
  logic       p_hard, p_rot, p_left, p_right, p_down;
  logic       rise_left, rise_right, rise_rot, rise_hard;
  logic       ev_left, ev_right, tick, hs, hs_hard;
  logic [2:0] top_cmd;

  assign rise_left  = (bus.keycode == KEY_LEFT)  && (key_prev != KEY_LEFT);
  assign rise_right = (bus.keycode == KEY_RIGHT) && (key_prev != KEY_RIGHT);
  assign rise_rot   = (bus.keycode == KEY_ROT)   && (key_prev != KEY_ROT);
  assign rise_hard  = (bus.keycode == KEY_HARD)  && (key_prev != KEY_HARD);
  assign hs         = (state == OFFER) && bus.cmd_ready && bus.enable;
  assign hs_hard    = hs && (bus.cmd == CMD_HARD);

  // A period shrinking below the running count wraps the counter without a tick.
  always_comb begin
    gp_eff = (bus.gravity_period == 6'd0) ? 6'd1 : bus.gravity_period;
    period = gp_eff;
    if ((bus.keycode == KEY_SOFT) && (SOFT_P < gp_eff)) period = SOFT_P;
    period8   = {2'b00, period};
    tick      = 1'b0;
    grav_next = grav_cnt + 8'd1;
    if (grav_cnt >= period8 - 8'd1) begin
      grav_next = 8'd0;
      tick      = (grav_cnt == period8 - 8'd1);
    end
  end

  always_comb begin
    if (p_hard)       top_cmd = CMD_HARD;
    else if (p_rot)   top_cmd = CMD_ROT;
    else if (p_left)  top_cmd = CMD_LEFT;
    else if (p_right) top_cmd = CMD_RIGHT;
    else if (p_down)  top_cmd = CMD_DOWN;
    else              top_cmd = CMD_NONE;
  end

`ifdef TETRIS_AUTOREPEAT_EN
  localparam int             HW     = $clog2(DAS_FRAMES + ARR_FRAMES + 1);
  localparam logic [HW-1:0]  DAS_C  = HW'(DAS_FRAMES);
  localparam logic [HW-1:0]  TOP_C  = HW'(DAS_FRAMES + ARR_FRAMES);
  localparam logic [HW-1:0]  LOOP_C = HW'(DAS_FRAMES + 1);

  logic [HW-1:0] hold_cnt, hold_k, hold_next;
  logic          lr_held, lr_rise, repeat_ev;

  // Once repeating, the count cycles DAS+1..DAS+ARR so it never overflows.
  always_comb begin
    lr_held   = (bus.keycode == KEY_LEFT) || (bus.keycode == KEY_RIGHT);
    lr_rise   = rise_left || rise_right;
    hold_k    = lr_rise ? '0 : hold_cnt;
    repeat_ev = lr_held && !lr_rise && ((hold_k == DAS_C) || (hold_k == TOP_C));
    if (!lr_held)              hold_next = '0;
    else if (hold_k == TOP_C)  hold_next = LOOP_C;
    else                       hold_next = hold_k + HW'(1);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset)           hold_cnt <= '0;
    else if (bus.enable) hold_cnt <= hold_next;
  end

  assign ev_left  = rise_left  || (repeat_ev && (bus.keycode == KEY_LEFT));
  assign ev_right = rise_right || (repeat_ev && (bus.keycode == KEY_RIGHT));
`else
  assign ev_left  = rise_left;
  assign ev_right = rise_right;
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= IDLE;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= CMD_NONE;
      key_prev      <= 8'd0;
      grav_cnt      <= 8'd0;
      p_hard        <= 1'b0;
      p_rot         <= 1'b0;
      p_left        <= 1'b0;
      p_right       <= 1'b0;
      p_down        <= 1'b0;
    end else begin
      key_prev <= bus.keycode;
      if (!bus.enable) begin
        state         <= IDLE;
        bus.cmd_valid <= 1'b0;
        bus.cmd       <= CMD_NONE;
        p_hard        <= 1'b0;
        p_rot         <= 1'b0;
        p_left        <= 1'b0;
        p_right       <= 1'b0;
        p_down        <= 1'b0;
      end else begin
        grav_cnt <= hs_hard ? 8'd0 : grav_next;
        // New events beat the handshake clear landing on the same edge.
        p_hard  <= rise_hard || (p_hard && !(hs && bus.cmd == CMD_HARD));
        p_rot   <= rise_rot  || (p_rot  && !(hs && bus.cmd == CMD_ROT));
        p_left  <= ev_left   || (p_left  && !ev_right && !(hs && bus.cmd == CMD_LEFT));
        p_right <= ev_right  || (p_right && !ev_left  && !(hs && bus.cmd == CMD_RIGHT));
        p_down  <= tick      || (p_down && !hs_hard && !(hs && bus.cmd == CMD_DOWN));
        case (state)
          IDLE: begin
            if (top_cmd != CMD_NONE) begin
              state         <= OFFER;
              bus.cmd_valid <= 1'b1;
              bus.cmd       <= top_cmd;
            end
          end
          OFFER: begin
            if (bus.cmd_ready) begin
              state         <= IDLE;
              bus.cmd_valid <= 1'b0;
              bus.cmd       <= CMD_NONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tetris_input_sched.sv
// Randomised and directed bench for tetris_input_sched against a cycle-level behavioural model.
module tb_tetris_input_sched;
  localparam int         DAS = 10;
  localparam int         ARR = 3;
  localparam int         SOFT = 2;
  localparam logic [7:0] K_LEFT = 8'h04, K_RIGHT = 8'h07, K_ROT = 8'h1A, K_SOFT = 8'h16, K_HARD = 8'h2C;

  logic frame_clk;
  logic Reset;
  tetris_input_sched_if bus_i ();

  tetris_input_sched dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus_i)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  int checks = 0;
  int errors = 0;
  int hs_cnt[8];

  // Behavioural model: pending set indexed by command code, gravity phase, hold length.
  bit         m_pend[6];
  int         m_offer = 0;
  int         m_phase = 0;
  int         m_held  = 0;
  logic [7:0] m_prev  = 8'd0;
  int         prio[5] = '{5, 3, 1, 2, 4};

  always @(posedge frame_clk) begin : model
    bit         ev[6];
    bit         np[6];
    bit         hs, tick, rise;
    int         per, kk;
    logic [7:0] key;
    key = bus_i.keycode;
    if (Reset) begin
      for (int c = 0; c < 6; c++) m_pend[c] = 1'b0;
      m_offer = 0; m_phase = 0; m_held = 0; m_prev = 8'd0;
    end else begin
      if (!bus_i.enable) begin
        for (int c = 0; c < 6; c++) m_pend[c] = 1'b0;
        m_offer = 0;
      end else begin
        hs  = (m_offer != 0) && bus_i.cmd_ready;
        per = (bus_i.gravity_period == 6'd0) ? 1 : int'(bus_i.gravity_period);
        if (key == K_SOFT && SOFT < per) per = SOFT;
        tick    = (m_phase == per - 1);
        m_phase = (m_phase >= per - 1) ? 0 : m_phase + 1;
        if (hs && m_offer == 5) m_phase = 0;
        for (int c = 0; c < 6; c++) ev[c] = 1'b0;
        ev[5] = (key == K_HARD)  && (m_prev != K_HARD);
        ev[3] = (key == K_ROT)   && (m_prev != K_ROT);
        ev[1] = (key == K_LEFT)  && (m_prev != K_LEFT);
        ev[2] = (key == K_RIGHT) && (m_prev != K_RIGHT);
        ev[4] = tick;
`ifdef TETRIS_AUTOREPEAT_EN
        if (key == K_LEFT || key == K_RIGHT) begin
          rise = (key != m_prev);
          kk   = rise ? 0 : m_held;
          if (!rise && (kk == DAS || (kk > DAS && (kk - DAS) % ARR == 0)))
            ev[(key == K_LEFT) ? 1 : 2] = 1'b1;
          m_held = kk + 1;
        end else begin
          m_held = 0;
        end
`else
        rise = 1'b0; kk = 0;
`endif
        for (int c = 1; c < 6; c++) np[c] = ev[c] || (m_pend[c] && !(hs && m_offer == c));
        if (ev[2]) np[1] = 1'b0;
        if (ev[1]) np[2] = 1'b0;
        if (hs && m_offer == 5 && !ev[4]) np[4] = 1'b0;
        if (m_offer != 0) begin
          if (bus_i.cmd_ready) m_offer = 0;
        end else begin
          for (int j = 0; j < 5; j++) if (m_offer == 0 && m_pend[prio[j]]) m_offer = prio[j];
        end
        for (int c = 1; c < 6; c++) m_pend[c] = np[c];
      end
      m_prev = key;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge frame_clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycles(2);
    Reset = 1'b0;
  endtask

  task automatic run_tests();
    int b0, b1, b2, hold;
    Reset = 1'b1; bus_i.keycode = 8'd0; bus_i.enable = 1'b1;
    bus_i.gravity_period = 6'd63; bus_i.cmd_ready = 1'b1;
    cycles(5);
    chk("reset_valid", int'(bus_i.cmd_valid), 0);
    chk("reset_cmd", int'(bus_i.cmd), 0);

    // Single ROT press: valid two cycles after the key change, exactly one handshake.
    Reset = 1'b0; bus_i.keycode = K_ROT; b0 = hs_cnt[3];
    cycles(1); chk("rot_lat1_valid", int'(bus_i.cmd_valid), 0);
    cycles(1); chk("rot_lat2_valid", int'(bus_i.cmd_valid), 1);
    chk("rot_lat2_cmd", int'(bus_i.cmd), 3);
    cycles(3); bus_i.keycode = 8'd0;
    cycles(3); chk("rot_once", hs_cnt[3] - b0, 1);

    // Gravity period 4, then soft drop period 2.
    bus_i.gravity_period = 6'd4;
    cycles(8); b0 = hs_cnt[4];
    cycles(16); chk("grav4_downs", hs_cnt[4] - b0, 4);
    bus_i.keycode = K_SOFT;
    cycles(6); b0 = hs_cnt[4];
    cycles(16); chk("soft_downs", hs_cnt[4] - b0, 8);
    bus_i.keycode = 8'd0; bus_i.gravity_period = 6'd63;

    // LEFT held 20 cycles.
    do_reset(); bus_i.keycode = K_LEFT; b0 = hs_cnt[1];
    cycles(20); bus_i.keycode = 8'd0;
    cycles(6);
`ifdef TETRIS_AUTOREPEAT_EN
    chk("left_held_count", hs_cnt[1] - b0, 5);
`else
    chk("left_held_count", hs_cnt[1] - b0, 1);
`endif

    // ROT offered with DOWN pending, HARD arrives, then ready.
    bus_i.cmd_ready = 1'b0; bus_i.gravity_period = 6'd8;
    do_reset(); bus_i.keycode = K_ROT; b0 = hs_cnt[3]; b1 = hs_cnt[5];
    cycles(1); bus_i.keycode = 8'd0;
    cycles(2); chk("stall_rot_cmd", int'(bus_i.cmd), 3);
    bus_i.keycode = K_HARD;
    cycles(1); bus_i.keycode = 8'd0;
    cycles(6); chk("stable_rot_cmd", int'(bus_i.cmd), 3);
    chk("stable_rot_valid", int'(bus_i.cmd_valid), 1);
    bus_i.cmd_ready = 1'b1;
    cycles(1); chk("after_rot_valid", int'(bus_i.cmd_valid), 0);
    cycles(1); chk("hard_cmd", int'(bus_i.cmd), 5);
    cycles(1); chk("after_hard_valid", int'(bus_i.cmd_valid), 0);
    b2 = hs_cnt[4];
    cycles(8); chk("down_cleared_by_hard", hs_cnt[4] - b2, 0);
    chk("no_early_down", int'(bus_i.cmd_valid), 0);
    cycles(1); chk("down_after_restart", int'(bus_i.cmd), 4);
    chk("rot_hs_once", hs_cnt[3] - b0, 1);
    chk("hard_hs_once", hs_cnt[5] - b1, 1);
    bus_i.gravity_period = 6'd63;

    // LEFT latched then RIGHT rise: both issued.
    bus_i.cmd_ready = 1'b0;
    do_reset(); bus_i.keycode = K_LEFT; b0 = hs_cnt[1]; b1 = hs_cnt[2];
    cycles(2); bus_i.keycode = K_RIGHT;
    cycles(1); bus_i.keycode = 8'd0;
    chk("left_latched", int'(bus_i.cmd), 1);
    bus_i.cmd_ready = 1'b1;
    cycles(4);
    chk("lr_left_hs", hs_cnt[1] - b0, 1);
    chk("lr_right_hs", hs_cnt[2] - b1, 1);

    // LEFT not yet latched when RIGHT rises: LEFT is dropped.
    bus_i.cmd_ready = 1'b0;
    do_reset(); bus_i.keycode = K_ROT; b0 = hs_cnt[1]; b1 = hs_cnt[2]; b2 = hs_cnt[3];
    cycles(1); bus_i.keycode = K_LEFT;
    cycles(1); bus_i.keycode = K_RIGHT;
    cycles(1); bus_i.keycode = 8'd0;
    chk("rot_blocks_left", int'(bus_i.cmd), 3);
    bus_i.cmd_ready = 1'b1;
    cycles(4);
    chk("dropped_left_hs", hs_cnt[1] - b0, 0);
    chk("kept_right_hs", hs_cnt[2] - b1, 1);
    chk("first_rot_hs", hs_cnt[3] - b2, 1);

    // Reset during OFFER.
    bus_i.cmd_ready = 1'b0;
    do_reset(); bus_i.keycode = K_ROT;
    cycles(1); bus_i.keycode = 8'd0;
    cycles(1); chk("pre_reset_valid", int'(bus_i.cmd_valid), 1);
    Reset = 1'b1;
    cycles(1); chk("mid_reset_valid", int'(bus_i.cmd_valid), 0);
    chk("mid_reset_cmd", int'(bus_i.cmd), 0);
    Reset = 1'b0;
    cycles(4); chk("flags_cleared_valid", int'(bus_i.cmd_valid), 0);

    // enable low during OFFER.
    bus_i.keycode = K_ROT;
    cycles(1); bus_i.keycode = 8'd0;
    cycles(1); chk("pre_dis_valid", int'(bus_i.cmd_valid), 1);
    bus_i.enable = 1'b0;
    cycles(1); chk("dis_valid", int'(bus_i.cmd_valid), 0);
    cycles(2); bus_i.enable = 1'b1;
    cycles(4); chk("reen_idle_valid", int'(bus_i.cmd_valid), 0);
    bus_i.keycode = K_ROT;
    cycles(2); chk("reen_rot_cmd", int'(bus_i.cmd), 3);
    bus_i.keycode = 8'd0; bus_i.cmd_ready = 1'b1;
    cycles(3);

    // Randomised traffic; the per-cycle compare against the model does the checking.
    do_reset();
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 7))
          0: bus_i.keycode = 8'd0;
          1: bus_i.keycode = K_LEFT;
          2: bus_i.keycode = K_RIGHT;
          3: bus_i.keycode = K_ROT;
          4: bus_i.keycode = K_SOFT;
          5: bus_i.keycode = K_HARD;
          6: bus_i.keycode = 8'($urandom_range(0, 255));
          default: bus_i.keycode = K_LEFT;
        endcase
        hold = $urandom_range(1, 25);
      end
      hold--;
      bus_i.cmd_ready = ($urandom_range(0, 9) < 7);
      bus_i.enable    = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 49) == 0)
        bus_i.gravity_period = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
      Reset = ($urandom_range(0, 499) == 0);
      cycles(1);
    end
    Reset = 1'b0;
    cycles(2);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) hs_cnt[c] = 0;
    fork
      begin : monitor
        forever begin
          @(negedge frame_clk);
          chk("model_valid", int'(bus_i.cmd_valid), (m_offer != 0) ? 1 : 0);
          chk("model_cmd", int'(bus_i.cmd), m_offer);
          if (bus_i.cmd_valid && bus_i.cmd_ready && bus_i.enable && !Reset)
            hs_cnt[bus_i.cmd]++;
        end
      end
      run_tests();
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
